// File: rtl/timer_pkg.sv
// Shared definitions for the timer run-control slice: FSM state encoding and the default lap width.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } timer_state_t;

    localparam int LAP_W_DEF = 4;

endpackage

// File: rtl/timer_lap_counter.sv
// Lap counter: lap count, latched lap target, and the "next step completes the target" flag.
module timer_lap_counter
    import timer_pkg::*;
#(
    parameter int LAP_W = LAP_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [LAP_W-1:0] laps,
    input  logic             step,
    output logic [LAP_W-1:0] lap_cnt,
    output logic             done
);

    logic [LAP_W-1:0] target;
    logic [LAP_W-1:0] lap_nxt;

    assign lap_nxt = lap_cnt + LAP_W'(1);

    // A zero target means periodic operation, which never completes.
    assign done = (target != '0) && (lap_nxt == target);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_cnt <= '0;
            target  <= '0;
        end else if (load) begin
            lap_cnt <= '0;
            target  <= laps;
        end else if (step) begin
            lap_cnt <= lap_nxt;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Run-control wrapper around the timer down counter: tick gating, lap counting and alarm.
// Optional pause support is compiled in with TIMER_CTRL_PAUSE_EN.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int LAP_W       = LAP_W_DEF,
    parameter int ALARM_TICKS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_tick,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_ack,
    input  logic             i_pause,
    input  logic [LAP_W-1:0] i_laps,
    input  logic             i_carry,
    output logic             o_en,
    output logic             o_busy,
    output logic             o_alarm,
    output logic             o_lap,
    output logic [LAP_W-1:0] o_laps
);

    localparam int AW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
    localparam logic [AW-1:0] ALARM_LAST = (ALARM_TICKS == 0) ? '0 : AW'(ALARM_TICKS - 1);

    timer_state_t state_q, state_d;
    logic [AW-1:0] alarm_cnt;
    logic          pause_eff;
    logic          expiry;
    logic          step;
    logic          load;
    logic          done;
    logic          timeout;
    logic          lap_q;

`ifdef TIMER_CTRL_PAUSE_EN
    assign pause_eff = i_pause;
`else
    logic unused_pause;
    assign unused_pause = i_pause;
    assign pause_eff    = 1'b0;
`endif

    assign o_en    = i_tick & (state_q == RUN) & ~pause_eff;
    // Carry is qualified by the enable so a held carry level counts once per wrap.
    assign expiry  = o_en & i_carry;
    assign load    = i_start & ~i_stop;
    assign step    = expiry & ~i_stop & ~i_start;
    assign timeout = (ALARM_TICKS != 0) && i_tick && (alarm_cnt == ALARM_LAST);

    timer_lap_counter #(
        .LAP_W (LAP_W)
    ) u_lap (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .laps    (i_laps),
        .step    (step),
        .lap_cnt (o_laps),
        .done    (done)
    );

    always_comb begin
        state_d = state_q;
        if (i_stop) begin
            state_d = IDLE;
        end else if (i_start) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
`ifdef TIMER_CTRL_PAUSE_EN
                    if (pause_eff)
                        state_d = PAUSE;
                    else
`endif
                    if (expiry && done)
                        state_d = ALARM;
                end
`ifdef TIMER_CTRL_PAUSE_EN
                PAUSE: begin
                    if (!pause_eff)
                        state_d = RUN;
                end
`endif
                ALARM: begin
                    if (i_ack || timeout)
                        state_d = IDLE;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lap_q   <= step;
        end
    end

    // Held at zero outside ALARM, so it is clear on every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            alarm_cnt <= '0;
        else if (state_q != ALARM)
            alarm_cnt <= '0;
        else if (i_tick)
            alarm_cnt <= alarm_cnt + AW'(1);
    end

    assign o_busy  = (state_q == RUN) || (state_q == PAUSE);
    assign o_alarm = (state_q == ALARM);
    assign o_lap   = lap_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed self-checking bench for timer_ctrl (LAP_W=4, ALARM_TICKS=8).
module tb_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_tick, i_start, i_stop, i_ack, i_pause, i_carry;
    logic [3:0] i_laps;
    logic       o_en, o_busy, o_alarm, o_lap;
    logic [3:0] o_laps;

    int n_err = 0;
    int n_chk = 0;
    int alarm_seen;

    timer_ctrl #(
        .LAP_W       (4),
        .ALARM_TICKS (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_tick  (i_tick),
        .i_start (i_start),
        .i_stop  (i_stop),
        .i_ack   (i_ack),
        .i_pause (i_pause),
        .i_laps  (i_laps),
        .i_carry (i_carry),
        .o_en    (o_en),
        .o_busy  (o_busy),
        .o_alarm (o_alarm),
        .o_lap   (o_lap),
        .o_laps  (o_laps)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        i_tick = 0; i_start = 0; i_stop = 0; i_ack = 0; i_carry = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; idle_in(); i_pause = 0; i_laps = 4'd0;
        cyc(); cyc();
        chk("rst_en", o_en, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_alarm", o_alarm, 0);
        chk("rst_lap", o_lap, 0);
        chk("rst_laps", o_laps, 0);
        rst_n = 1;
        cyc();

        // Three-lap run: tick every 4 clk, carry on every 2nd enabled tick
        i_laps = 4'd3; i_start = 1;
        cyc();
        i_start = 0; i_laps = 4'd0;
        chk("start_busy", o_busy, 1);
        chk("start_laps", o_laps, 0);
        for (int t = 1; t <= 6; t++) begin
            cyc(); cyc(); cyc();
            i_tick = 1; i_carry = (t % 2 == 0);
            #1 chk("run_en", o_en, 1);
            cyc();
            i_tick = 0; i_carry = 0;
            chk("run_lap", o_lap, (t % 2 == 0));
            chk("run_laps", o_laps, t / 2);
        end
        chk("alarm_set", o_alarm, 1);
        chk("alarm_busy", o_busy, 0);

        // Alarm auto-clear after 8 ticks
        for (int k = 1; k <= 8; k++) begin
            i_tick = 1;
            #1 if (k == 1) chk("alarm_en", o_en, 0);
            cyc();
            i_tick = 0;
            chk("alarm_hold", o_alarm, (k < 8));
            cyc();
        end
        chk("alarm_laps_kept", o_laps, 3);

        // Alarm cleared by ack on the 2nd tick
        i_laps = 4'd1; i_start = 1;
        cyc();
        i_start = 0; i_tick = 1; i_carry = 1;
        cyc();
        i_tick = 0; i_carry = 0;
        chk("ack_alarm", o_alarm, 1);
        chk("ack_lap", o_lap, 1);
        i_tick = 1;
        cyc();
        i_ack = 1;
        cyc();
        i_tick = 0; i_ack = 0;
        chk("ack_clear", o_alarm, 0);
        chk("ack_busy", o_busy, 0);

        // Periodic: 20 expiries with carry held as a level
        i_laps = 4'd0; i_start = 1;
        cyc();
        i_start = 0; alarm_seen = 0;
        for (int k = 1; k <= 20; k++) begin
            i_tick = 1; i_carry = 1;
            cyc();
            if (o_alarm) alarm_seen++;
            if (k == 15) chk("per_15", o_laps, 15);
            if (k == 16) chk("per_wrap", o_laps, 0);
        end
        chk("per_20", o_laps, 4);
        chk("per_lap", o_lap, 1);
        i_tick = 0;
        cyc(); cyc(); cyc();
        chk("per_carry_only", o_laps, 4);
        chk("per_no_alarm", alarm_seen, 0);
        i_carry = 0;

        // Stop, then start+stop together in IDLE
        i_stop = 1;
        cyc();
        chk("stop_busy", o_busy, 0);
        chk("stop_laps_kept", o_laps, 4);
        i_start = 1; i_laps = 4'd5;
        cyc();
        idle_in();
        chk("ss_busy", o_busy, 0);
        chk("ss_laps", o_laps, 4);

        // Stop coincident with the final-lap expiry
        i_laps = 4'd2; i_start = 1;
        cyc();
        i_start = 0; i_tick = 1; i_carry = 1;
        cyc();
        chk("fin_laps1", o_laps, 1);
        i_stop = 1;
        #1 chk("fin_en", o_en, 1);
        cyc();
        idle_in();
        chk("fin_lap", o_lap, 0);
        chk("fin_alarm", o_alarm, 0);
        chk("fin_busy", o_busy, 0);
        chk("fin_laps", o_laps, 1);

        // Start coincident with an expiry in RUN
        i_laps = 4'd2; i_start = 1;
        cyc();
        i_start = 0; i_tick = 1; i_carry = 1;
        cyc();
        chk("rs_laps1", o_laps, 1);
        i_start = 1;
        cyc();
        i_start = 0; i_tick = 0; i_carry = 0;
        chk("rs_laps", o_laps, 0);
        chk("rs_lap", o_lap, 0);
        chk("rs_busy", o_busy, 1);

        // Asynchronous reset mid-RUN
        i_tick = 1; i_carry = 1;
        cyc();
        chk("mr_laps", o_laps, 1);
        rst_n = 0;
        #1;
        chk("mr_en", o_en, 0);
        chk("mr_busy", o_busy, 0);
        chk("mr_laps0", o_laps, 0);
        chk("mr_lap", o_lap, 0);
        chk("mr_alarm", o_alarm, 0);
        cyc();
        rst_n = 1;
        cyc();
        chk("mr_idle_en", o_en, 0);
        chk("mr_idle_busy", o_busy, 0);
        idle_in();

        // Pause behaviour
        i_laps = 4'd0; i_start = 1;
        cyc();
        i_start = 0; i_pause = 1;
`ifdef TIMER_CTRL_PAUSE_EN
        for (int k = 1; k <= 10; k++) begin
            i_tick = 1; i_carry = 1;
            #1 chk("pause_en", o_en, 0);
            cyc();
            chk("pause_busy", o_busy, 1);
            chk("pause_laps", o_laps, 0);
        end
        i_pause = 0; i_tick = 0;
        cyc();
        i_tick = 1;
        #1 chk("resume_en", o_en, 1);
        cyc();
        i_tick = 0; i_carry = 0;
        chk("resume_laps", o_laps, 1);
`else
        for (int k = 1; k <= 3; k++) begin
            i_tick = 1; i_carry = 1;
            #1 chk("nopause_en", o_en, 1);
            cyc();
            chk("nopause_laps", o_laps, k);
        end
        i_tick = 0; i_carry = 0; i_pause = 0;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
